// File: rtl/fib_bcd_converter.sv
// fib_bcd_converter: serial double-dabble binary-to-BCD stage with wrap detection
module fib_bcd_converter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_hundreds,
    output logic [3:0]       out_tens,
    output logic [3:0]       out_ones,
    output logic             out_wrap
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [11:0] bcd, adj;
    logic [WIDTH-1:0] shreg, last;
    logic [WIDTH+11:0] sh;
    logic [3:0] cnt;
    logic prev_valid;
    always_comb begin
        adj = {bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8],
               bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4],
               bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0]};
        sh = {adj, shreg} << 1;
    end
    assign {out_hundreds, out_tens, out_ones} = bcd;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_wrap   <= 1'b0;
            bcd        <= '0;
            shreg      <= '0;
            last       <= '0;
            cnt        <= '0;
            prev_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    shreg      <= in_data;
                    bcd        <= '0;
                    cnt        <= 4'(WIDTH - 1);
                    out_wrap   <= prev_valid && (in_data < last);
                    last       <= in_data;
                    prev_valid <= 1'b1;
                    in_ready   <= 1'b0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    bcd   <= sh[WIDTH+11:WIDTH];
                    shreg <= sh[WIDTH-1:0];
                    cnt   <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_bcd_converter.sv
// tb_fib_bcd_converter: directed and randomized checks of the BCD converter against a behavioural model
module tb_fib_bcd_converter;
    localparam int WIDTH = 8;
    logic clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready, out_wrap;
    logic [WIDTH-1:0] in_data;
    logic [3:0] out_hundreds, out_tens, out_ones;
    int total = 0, bad = 0;
    int m_left, m_val, m_last;
    logic m_done, m_prev, m_wrap, m_clr;

    fib_bcd_converter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_hundreds(out_hundreds), .out_tens(out_tens), .out_ones(out_ones),
        .out_wrap(out_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts edges from acceptance, digits from decimal arithmetic
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0; m_done <= 1'b0; m_prev <= 1'b0; m_wrap <= 1'b0;
            m_val <= 0; m_last <= 0; m_clr <= 1'b1;
        end else if (m_left == 0 && !m_done) begin
            if (in_valid) begin
                m_left <= WIDTH;
                m_val  <= int'(in_data);
                m_wrap <= m_prev && (int'(in_data) < m_last);
                m_last <= int'(in_data);
                m_prev <= 1'b1;
                m_clr  <= 1'b0;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_left == 0 && !m_done));
        chk("out_valid", int'(out_valid), int'(m_done));
        if (m_done) begin
            chk("hundreds", int'(out_hundreds), m_val / 100);
            chk("tens", int'(out_tens), (m_val / 10) % 10);
            chk("ones", int'(out_ones), m_val % 10);
            chk("wrap", int'(out_wrap), int'(m_wrap));
        end else if (m_clr) begin
            chk("clr_digits", int'({out_hundreds, out_tens, out_ones}), 0);
            chk("clr_wrap", int'(out_wrap), 0);
        end
    end

    task automatic xfer(input int v, input int hold, input int h, input int t, input int o, input int w);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = WIDTH'(v); out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_data = WIDTH'($urandom);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, WIDTH + 1);
        chk("lit_digits", int'({out_hundreds, out_tens, out_ones}), (h << 8) | (t << 4) | o);
        chk("lit_wrap", int'(out_wrap), w);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_ready", int'(in_ready), 0);
            chk("hold_digits", int'({out_hundreds, out_tens, out_ones}), (h << 8) | (t << 4) | o);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", int'(out_valid), 0);
        chk("post_ready", int'(in_ready), 1);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_digits", int'({out_hundreds, out_tens, out_ones}), 0);
        chk("rst_wrap", int'(out_wrap), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(in_ready), 1);
        chk("reset_valid", int'(out_valid), 0);
        reset = 1'b0;
        xfer(0, 0, 0, 0, 0, 0);
        xfer(233, 0, 2, 3, 3, 0);
        xfer(255, 0, 2, 5, 5, 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd77;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        pulse_reset();
        xfer(144, 0, 1, 4, 4, 0);
        xfer(233, 0, 2, 3, 3, 0);
        xfer(121, 0, 1, 2, 1, 1);
        xfer(89, 5, 0, 8, 9, 1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        pulse_reset();
        xfer(13, 0, 0, 1, 3, 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = 1'($urandom);
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
